// File: rtl/pipe_skid_reg_pkg.sv
// Shared definitions for the posedge elastic pipeline register: state encoding,
// default payload width and a state-to-occupancy helper.
package pipe_skid_reg_pkg;

    localparam int SKID_DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'b00,
        SKID_ONE   = 2'b01,
        SKID_FULL  = 2'b10
    } skid_state_t;

    // Occupancy implied by a state; unknown encodings read as empty.
    function automatic logic [1:0] skid_count(input skid_state_t s);
        case (s)
            SKID_ONE:  return 2'd1;
            SKID_FULL: return 2'd2;
            default:   return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_skid_reg.sv
// Two-entry skid pipeline register with valid/ready handshake. All outputs,
// including in_ready, are registered decodes of the next state.
module pipe_skid_reg
    import pipe_skid_reg_pkg::*;
#(
    parameter int WIDTH = SKID_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       count
);

    skid_state_t      state_reg;
    skid_state_t      state_next;
    logic [WIDTH-1:0] main_reg;
    logic [WIDTH-1:0] main_next;
    logic [WIDTH-1:0] skid_reg;
    logic [WIDTH-1:0] skid_next;
    logic             in_ready_reg;
    logic             out_valid_reg;
    logic [1:0]       count_reg;

    logic push;
    logic pop;

    assign push = in_valid & in_ready_reg;
    assign pop  = out_valid_reg & out_ready;

    always_comb begin
        state_next = state_reg;
        main_next  = main_reg;
        skid_next  = skid_reg;

        case (state_reg)
            SKID_EMPTY: begin
                if (push) begin
                    state_next = SKID_ONE;
                    main_next  = in_data;
                end
            end
            SKID_ONE: begin
                if (push && !pop) begin
                    state_next = SKID_FULL;
                    skid_next  = in_data;
                end else if (push && pop) begin
                    main_next  = in_data;
                end else if (pop) begin
                    state_next = SKID_EMPTY;
                end
            end
            SKID_FULL: begin
                // in_ready is low here, so only a pop can move the state.
                if (pop) begin
                    state_next = SKID_ONE;
                    main_next  = skid_reg;
                end
            end
            default: begin
                state_next = SKID_EMPTY;
            end
        endcase

        // A squash empties the stage but leaves the data registers untouched.
        if (flush) begin
            state_next = SKID_EMPTY;
            main_next  = main_reg;
            skid_next  = skid_reg;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_reg     <= SKID_EMPTY;
            main_reg      <= '0;
            skid_reg      <= '0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            count_reg     <= 2'd0;
        end else begin
            state_reg     <= state_next;
            main_reg      <= main_next;
            skid_reg      <= skid_next;
            in_ready_reg  <= (state_next != SKID_FULL);
            out_valid_reg <= (state_next == SKID_ONE) || (state_next == SKID_FULL);
            count_reg     <= skid_count(state_next);
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign out_data  = main_reg;
    assign count     = count_reg;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Scoreboard bench for pipe_skid_reg: directed scenarios plus random valid/ready
// traffic, checked against a FIFO reference of capacity two.
module tb_pipe_skid_reg;

    localparam int WIDTH = 32;

    logic             clk;
    logic             clr;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [WIDTH-1:0] exp_q[$];
    logic             mon_push;
    logic             mon_pop;
    logic [WIDTH-1:0] mon_exp;

    pipe_skid_reg #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .clr       (clr),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: on the falling edge the inputs and registered outputs are stable,
    // and describe exactly the transfer the next rising edge will perform.
    always @(negedge clk) begin
        if (clr) begin
            exp_q.delete();
        end else begin
            check("count_vs_model", 32'(count), 32'(exp_q.size()));
            check("out_valid_vs_model", 32'(out_valid), 32'(exp_q.size() != 0));
            check("in_ready_vs_model", 32'(in_ready), 32'(exp_q.size() < 2));
            mon_push = in_valid && in_ready;
            mon_pop  = out_valid && out_ready;
            if (mon_pop) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL pop_on_empty: got data %h, expected no valid output", out_data);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("out_data_order", out_data, mon_exp);
                end
            end
            if (flush) exp_q.delete();
            else if (mon_push) exp_q.push_back(in_data);
            if (mon_push || mon_pop || flush)
                $display("xfer t=%0t push=%0d in=%h pop=%0d out=%h flush=%0d",
                         $time, mon_push, in_data, mon_pop, out_data, flush);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    logic acc;

    initial begin
        clr = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (2) step();

        // Reset mid-cycle while an entry is held.
        clr = 1'b0; in_valid = 1'b1; in_data = 32'h99;
        step();
        in_valid = 1'b0;
        #2 clr = 1'b1;
        #1;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_data", out_data, 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_count", 32'(count), 32'd0);
        step();
        clr = 1'b0; in_valid = 1'b1; in_data = 32'h0000_00A5;
        step();
        in_valid = 1'b0;
        check("first_push_valid", 32'(out_valid), 32'd1);
        check("first_push_data", out_data, 32'h0000_00A5);
        out_ready = 1'b1;
        repeat (2) step();

        // Streaming at full rate.
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1; in_data = 32'(i); out_ready = 1'b1;
            step();
            check("stream_in_ready", 32'(in_ready), 32'd1);
            check("stream_count", 32'(count), 32'd1);
        end
        in_valid = 1'b0;
        step();
        check("stream_drained", 32'(count), 32'd0);

        // Backpressure fills both entries and refuses a third.
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h11;
        step();
        in_data = 32'h22;
        step();
        check("bp_count_full", 32'(count), 32'd2);
        check("bp_in_ready_low", 32'(in_ready), 32'd0);
        in_data = 32'h33;
        step();
        check("bp_still_full", 32'(count), 32'd2);
        out_ready = 1'b1;
        step();
        check("bp_in_ready_back", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        repeat (3) step();

        // Flush from FULL with a concurrent offer and pop.
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h44;
        step();
        in_data = 32'h55;
        step();
        check("flush_pre_count", 32'(count), 32'd2);
        flush = 1'b1; in_data = 32'h66; out_ready = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        check("flush_count", 32'(count), 32'd0);
        check("flush_out_valid", 32'(out_valid), 32'd0);
        repeat (2) step();

        // Push and pop together while holding one entry.
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h77;
        step();
        check("simul_main", out_data, 32'h77);
        in_data = 32'h88; out_ready = 1'b1;
        step();
        in_valid = 1'b0; out_ready = 1'b0;
        check("simul_count", 32'(count), 32'd1);
        check("simul_data", out_data, 32'h88);
        out_ready = 1'b1;
        repeat (2) step();

        // Random traffic; an unaccepted offer is held stable.
        acc = 1'b1;
        for (int c = 0; c < 10000; c++) begin
            if (!in_valid || acc || flush) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_data  = $urandom;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            acc       = in_valid && in_ready;
            step();
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) step();
        check("final_empty", 32'(count), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_skid_reg.md
# pipe_skid_reg

Posedge-clocked elastic pipeline register that carries one instruction/operand payload between two processor stages with a valid/ready handshake. It is the consumer-side counterpart of the falling-edge state elements. Values written on the negative edge are picked up here on the following rising edge and handed downstream without bubbles. A two-entry skid buffer keeps `in_ready` fully registered, so no combinational path runs from `out_ready` to `in_ready`. `flush` squashes the stage's contents on a branch or exception.

## Interface
- `WIDTH`, 32, payload width in bits (≥1)
- `clk`  in  1  rising-edge clock; all state updates on posedge only
- `clr`  in  1  asynchronous, active-high reset
- `flush`  in  1  synchronous squash of all held entries
- `in_valid`  in  1  upstream offers `in_data`
- `in_ready`  out  1  buffer can accept; registered
- `in_data`  in  WIDTH  upstream payload
- `out_valid`  out  1  `out_data` is valid; registered
- `out_ready`  in  1  downstream accepts this cycle
- `out_data`  out  WIDTH  head payload; registered
- `count`  out  2  entries held (0..2); registered

## Operation
- Storage: `main` (drives `out_data`) and `skid` (overflow), each with its own valid bit.
- States: EMPTY (count 0), ONE (main valid), FULL (main and skid valid).
- Transfers: push = `in_valid & in_ready`; pop = `out_valid & out_ready`.
- EMPTY:
  - push → ONE, main ← `in_data`.
- ONE:
  - push & ~pop → FULL, skid ← `in_data`.
  - push & pop → ONE, main ← `in_data`.
  - ~push & pop → EMPTY.
  - neither → ONE, hold.
- FULL:
  - `in_ready` = 0, so push is impossible.
  - pop → ONE, main ← skid, skid invalid.
  - no pop → hold.
- `in_ready` = 1 in EMPTY and ONE, 0 in FULL. It is a registered decode of next-state.
- `out_valid` = 1 in ONE and FULL.
- `count` tracks the state: 0, 1 or 2.
- Ordering: strict FIFO. Payload leaves in arrival order, bit-exact, never duplicated or dropped, except on `flush`/`clr`.
- Flush:
  - Next state is EMPTY regardless of push/pop in the same cycle.
  - A simultaneous push is discarded.
  - A simultaneous pop is still counted as consumed downstream.
  - `out_data` is unchanged on flush; it is don't-care while `out_valid`=0.
- Unused data registers hold their value; no zeroing except on reset.
- An X on the state register must never propagate. Any undefined state decode is forced to EMPTY.

## Timing
- Reset (`clr`=1, asynchronous, immediate):
  - State EMPTY, `out_valid`=0, `in_ready`=1, `count`=0.
  - `out_data`=0, skid data=0.
- Reset release: first push can occur on the first rising edge after `clr` falls.
- Latency: a push at edge N appears on `out_valid`/`out_data` after edge N (1 cycle) when the buffer was EMPTY.
- Throughput: 1 transfer per cycle sustained while `out_ready`=1.
- `in_ready` recovers 1 cycle after the pop that empties skid.
- `clr` asserted mid-transfer aborts it. No partial payload is visible after release.
- `flush` and `clr` together: `clr` wins.
- Upstream must hold `in_data` stable while `in_valid`=1 and `in_ready`=0.
- Downstream may deassert `out_ready` at any time without loss.

## Structure
- Shared processor package holds:
  - State encoding constants: `SKID_EMPTY`=2'b00, `SKID_ONE`=2'b01, `SKID_FULL`=2'b10.
  - Default payload width constant (32).
- No sub-module. Main/skid registers and next-state logic stay in one always block plus one combinational decode. Target 150–250 lines.

## Test plan
- Reset: assert `clr` mid-cycle with no clock edge → outputs 0/0/1/0 (`out_valid`/`out_data`/`in_ready`/`count`) immediately; release, push 0x0000_00A5 → `out_data`=0x0000_00A5, `out_valid`=1 one edge later.
- Streaming: push 0x1..0x8 on consecutive cycles with `out_ready`=1 → outputs 0x1..0x8 in order, one per cycle, `in_ready` never drops, `count`=1 throughout.
- Backpressure: `out_ready`=0, push 0x11, 0x22, attempt 0x33 → `count`=2, `in_ready`=0, 0x33 not accepted; raise `out_ready` → 0x11, 0x22, then 0x33 (re-offered) emerge in order.
- Flush: FULL with 0x44/0x55, assert `flush` together with `in_valid` (0x66) and `out_ready` → next cycle `count`=0, `out_valid`=0, 0x66 never appears.
- Simultaneous push and pop in ONE: main=0x77, push 0x88 with `out_ready`=1 → `count` stays 1, `out_data`=0x88 next cycle.
- Random valid/ready (10k cycles, scoreboard) against a reference queue → zero mismatches, `count` never >2, `in_ready`=~(count==2) every cycle.
